// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - trap prioritisation and entry/return sequencing for the RV32IC pipeline
module trap_sequencer #(
   parameter logic [31:0] VEC_NMI    = 32'd3741,
   parameter logic [31:0] VEC_ECALL  = 32'd3757,
   parameter logic [31:0] VEC_EBREAK = 32'd3773,
   parameter logic [31:0] VEC_TIMER  = 32'd3789,
   parameter logic [31:0] VEC_EXT    = 32'd3805
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        nmi,
   input  logic [7:0]  irq,
   input  logic        timer_irq,
   input  logic        ecall,
   input  logic        ebreak,
   input  logic        mret,
   input  logic [3:0]  mie,
   input  logic        boundary,
   input  logic [31:0] ex_pc,
   input  logic [31:0] next_pc,
   input  logic [31:0] mepc,
   input  logic        redirect_ack,
   output logic        flush,
   output logic        mepc_we,
   output logic [31:0] mepc_wdata,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic [2:0]  cause,
   output logic        in_handler
);

   typedef enum logic [2:0] {S_IDLE, S_SAVE, S_VECT, S_HANDLER, S_RET} state_t;

   state_t      r_state;
   state_t      w_next;
   logic        r_nmi_q;
   logic        r_nmi_pend;
   logic        r_nmi_active;
   logic        r_in_handler;
   logic [2:0]  r_cause;
   logic [31:0] r_vector;
   logic [31:0] r_mepc_wdata;

   logic        w_nmi_rise;
   logic        w_nmi_req;
   logic        w_timer_q;
   logic        w_ext_q;
   logic        w_ecall_q;
   logic [2:0]  w_irq_num;
   logic [31:0] w_ext_vec;
   logic [2:0]  w_sel_cause;
   logic [31:0] w_sel_vec;
   logic [31:0] w_sel_wdata;
   logic        w_take_idle;
   logic        w_take_nest;
   logic        w_take;

   // A fresh edge counts in the same cycle so an NMI beats sources sampled alongside it.
   assign w_nmi_rise = nmi & ~r_nmi_q;
   assign w_nmi_req  = r_nmi_pend | w_nmi_rise;
   assign w_timer_q  = timer_irq & mie[0] & mie[3];
   assign w_ext_q    = (|irq) & mie[1] & mie[3];
   assign w_ecall_q  = ecall & mie[2] & mie[3];

   always_comb begin
      w_irq_num = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (irq[i]) w_irq_num = i[2:0];
      end
   end

   assign w_ext_vec = VEC_EXT + ({29'd0, w_irq_num} << 4);

   always_comb begin
      w_sel_cause = 3'd0;
      w_sel_vec   = 32'd0;
      w_sel_wdata = next_pc;
      if (w_nmi_req) begin
         w_sel_cause = 3'd1;
         w_sel_vec   = VEC_NMI;
      end else if (ebreak) begin
         w_sel_cause = 3'd2;
         w_sel_vec   = VEC_EBREAK;
         w_sel_wdata = ex_pc;
      end else if (w_timer_q) begin
         w_sel_cause = 3'd3;
         w_sel_vec   = VEC_TIMER;
      end else if (w_ext_q) begin
         w_sel_cause = 3'd4;
         w_sel_vec   = w_ext_vec;
      end else if (w_ecall_q) begin
         w_sel_cause = 3'd5;
         w_sel_vec   = VEC_ECALL;
         w_sel_wdata = ex_pc;
      end
   end

   assign w_take_idle = (r_state == S_IDLE) && boundary && (w_sel_cause != 3'd0);
   assign w_take_nest = (r_state == S_HANDLER) && boundary && w_nmi_req && !r_nmi_active;
   assign w_take      = w_take_idle | w_take_nest;

   always_comb begin
      w_next         = r_state;
      flush          = 1'b0;
      mepc_we        = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      case (r_state)
         S_IDLE: begin
            if (w_take_idle) w_next = S_SAVE;
         end
         S_SAVE: begin
            flush   = 1'b1;
            mepc_we = 1'b1;
            w_next  = S_VECT;
         end
         S_VECT: begin
            flush          = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = r_vector;
            if (redirect_ack) w_next = S_HANDLER;
         end
         S_HANDLER: begin
            if (w_take_nest) w_next = S_SAVE;
            else if (mret)   w_next = S_RET;
         end
         S_RET: begin
            flush          = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = mepc;
            if (redirect_ack) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_nmi_q      <= 1'b0;
         r_nmi_pend   <= 1'b0;
         r_nmi_active <= 1'b0;
         r_in_handler <= 1'b0;
         r_cause      <= 3'd0;
         r_vector     <= 32'd0;
         r_mepc_wdata <= 32'd0;
      end else begin
         r_state <= w_next;
         r_nmi_q <= nmi;
         if (w_take && w_nmi_req) r_nmi_pend <= 1'b0;
         else if (w_nmi_rise)     r_nmi_pend <= 1'b1;
         if (w_take) begin
            r_cause      <= w_sel_cause;
            r_vector     <= w_sel_vec;
            r_mepc_wdata <= w_sel_wdata;
         end
         if (w_take_nest) r_nmi_active <= 1'b1;
         if (r_state == S_VECT && redirect_ack) r_in_handler <= 1'b1;
         if (r_state == S_RET && redirect_ack) begin
            r_cause      <= 3'd0;
            r_in_handler <= 1'b0;
            r_nmi_active <= 1'b0;
         end
      end
   end

   assign mepc_wdata = r_mepc_wdata;
   assign cause      = r_cause;
   assign in_handler = r_in_handler;

endmodule

// File: tb/tb_trap_sequencer.sv
// tb/tb_trap_sequencer.sv - scoreboard bench for trap_sequencer
module tb_trap_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        nmi;
   logic [7:0]  irq;
   logic        timer_irq;
   logic        ecall;
   logic        ebreak;
   logic        mret;
   logic [3:0]  mie;
   logic        boundary;
   logic [31:0] ex_pc;
   logic [31:0] next_pc;
   logic [31:0] mepc;
   logic        redirect_ack;
   logic        flush;
   logic        mepc_we;
   logic [31:0] mepc_wdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [2:0]  cause;
   logic        in_handler;

   typedef struct {
      logic [31:0] wdata;
      logic [31:0] vec;
      logic [2:0]  cause;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   trap_sequencer dut (
      .clk(clk), .rst(rst), .nmi(nmi), .irq(irq), .timer_irq(timer_irq),
      .ecall(ecall), .ebreak(ebreak), .mret(mret), .mie(mie), .boundary(boundary),
      .ex_pc(ex_pc), .next_pc(next_pc), .mepc(mepc), .redirect_ack(redirect_ack),
      .flush(flush), .mepc_we(mepc_we), .mepc_wdata(mepc_wdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .cause(cause), .in_handler(in_handler)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [31:0] w, input logic [31:0] v, input logic [2:0] c);
      exp_t e;
      e.wdata = w;
      e.vec   = v;
      e.cause = c;
      sb.push_back(e);
   endtask

   task automatic clr_src();
      nmi = 0; irq = 0; timer_irq = 0; ecall = 0; ebreak = 0;
   endtask

   // Waits for SAVE, checks entry latency, then the VECT cycle.
   task automatic take(input string tag, input int exp_lat);
      int   n;
      exp_t e;
      n = 0;
      do begin
         tick();
         n++;
      end while (mepc_we !== 1'b1 && n < 10);
      chk({tag, "_lat"}, n, exp_lat);
      chk({tag, "_sb"}, (sb.size() > 0), 1);
      if (sb.size() > 0) e = sb.pop_front();
      else begin
         e.wdata = 0; e.vec = 0; e.cause = 0;
      end
      chk({tag, "_wdata"}, mepc_wdata, e.wdata);
      chk({tag, "_cause"}, cause, e.cause);
      chk({tag, "_flush_s"}, flush, 1);
      tick();
      chk({tag, "_rv"}, redirect_valid, 1);
      chk({tag, "_vec"}, redirect_pc, e.vec);
      chk({tag, "_flush_v"}, flush, 1);
   endtask

   task automatic ack(input string tag);
      redirect_ack = 1;
      tick();
      redirect_ack = 0;
      chk({tag, "_inh"}, in_handler, 1);
      chk({tag, "_rv_off"}, redirect_valid, 0);
   endtask

   task automatic ret(input string tag, input logic [31:0] m);
      mret = 1;
      mepc = m;
      tick();
      mret = 0;
      chk({tag, "_ret_rv"}, redirect_valid, 1);
      chk({tag, "_ret_pc"}, redirect_pc, m);
      redirect_ack = 1;
      tick();
      redirect_ack = 0;
      chk({tag, "_ret_cause"}, cause, 0);
      chk({tag, "_ret_inh"}, in_handler, 0);
      chk({tag, "_ret_rv_off"}, redirect_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1; clr_src(); mret = 0; mie = 0; boundary = 0;
      ex_pc = 0; next_pc = 0; mepc = 0; redirect_ack = 0;
      tick(); tick();
      chk("rst_flush", flush, 0);
      chk("rst_mepc_we", mepc_we, 0);
      chk("rst_wdata", mepc_wdata, 0);
      chk("rst_rv", redirect_valid, 0);
      chk("rst_pc", redirect_pc, 0);
      chk("rst_cause", cause, 0);
      chk("rst_inh", in_handler, 0);
      rst = 0;
      boundary = 1;

      // T1 timer
      timer_irq = 1; mie = 4'b1001; next_pc = 32'h40;
      push(32'h40, 32'd3789, 3'd3);
      take("T1", 1);
      ack("T1");
      chk("T1_cause_held", cause, 3);
      clr_src();
      ret("T1", 32'h200);

      // T2 external, lowest set index wins
      irq = 8'b0010_0100; mie = 4'b1010; next_pc = 32'h80;
      push(32'h80, 32'd3837, 3'd4);
      take("T2", 1);
      ack("T2");
      clr_src();
      ret("T2", 32'h84);

      // EBREAK beats timer; timer stays pending and is taken after return
      ebreak = 1; timer_irq = 1; mie = 4'b1001; ex_pc = 32'h120; next_pc = 32'h124;
      push(32'h120, 32'd3773, 3'd2);
      push(32'h124, 32'd3789, 3'd3);
      take("EB", 1);
      ack("EB");
      ebreak = 0;
      ret("EB", 32'h124);
      take("EB_TMR", 1);
      ack("EB_TMR");
      clr_src();
      ret("EB_TMR", 32'h128);

      // T3 NMI beats simultaneous ebreak/timer; those are ignored in handler
      nmi = 1; ebreak = 1; timer_irq = 1; mie = 4'b1001; next_pc = 32'h300;
      push(32'h300, 32'd3741, 3'd1);
      take("T3", 1);
      nmi = 0;
      ack("T3");
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("T3_ign_we", mepc_we, 0);
         chk("T3_ign_cause", cause, 1);
      end
      clr_src();
      ret("T3", 32'h300);

      // Nested NMI, then a second NMI held off until return
      timer_irq = 1; mie = 4'b1001; next_pc = 32'h400;
      push(32'h400, 32'd3789, 3'd3);
      take("NS1", 1);
      ack("NS1");
      clr_src();
      next_pc = 32'h500;
      nmi = 1;
      push(32'h500, 32'd3741, 3'd1);
      take("NS2", 1);
      nmi = 0;
      ack("NS2");
      nmi = 1;
      tick();
      nmi = 0;
      chk("NS3_hold_we", mepc_we, 0);
      tick();
      chk("NS3_hold_we2", mepc_we, 0);
      ret("NS2", 32'h504);
      push(32'h500, 32'd3741, 3'd1);
      take("NS3", 1);
      ack("NS3");
      ret("NS3", 32'h504);

      // T4 ECALL, then masked globally
      ecall = 1; ex_pc = 32'h100; next_pc = 32'h104; mie = 4'b1100;
      push(32'h100, 32'd3757, 3'd5);
      take("T4", 1);
      ack("T4");
      ecall = 0;
      ret("T4", 32'h104);
      ecall = 1; mie = 4'b0100;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("T4_mask_we", mepc_we, 0);
         chk("T4_mask_rv", redirect_valid, 0);
      end
      clr_src();

      // MRET in IDLE does nothing
      mret = 1; mepc = 32'h777;
      tick();
      chk("MRET_idle_rv", redirect_valid, 0);
      chk("MRET_idle_flush", flush, 0);
      mret = 0;

      // Sources wait for the retire boundary
      boundary = 0; timer_irq = 1; mie = 4'b1001; next_pc = 32'h600;
      tick();
      chk("BND_we0", mepc_we, 0);
      tick();
      chk("BND_we1", mepc_we, 0);
      push(32'h600, 32'd3789, 3'd3);
      boundary = 1;
      take("T5", 1);
      clr_src();
      // T5 redirect held while ack is low
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("T5_hold_rv", redirect_valid, 1);
         chk("T5_hold_pc", redirect_pc, 32'd3789);
      end
      ack("T5");
      ret("T5", 32'h104);

      // T6 reset during VECT with a latched NMI
      timer_irq = 1; mie = 4'b1001; next_pc = 32'h700;
      push(32'h700, 32'd3789, 3'd3);
      take("T6", 1);
      clr_src();
      nmi = 1;
      tick();
      nmi = 0;
      chk("T6_vect_rv", redirect_valid, 1);
      rst = 1;
      tick();
      chk("T6_flush", flush, 0);
      chk("T6_we", mepc_we, 0);
      chk("T6_wdata", mepc_wdata, 0);
      chk("T6_rv", redirect_valid, 0);
      chk("T6_pc", redirect_pc, 0);
      chk("T6_cause", cause, 0);
      chk("T6_inh", in_handler, 0);
      rst = 0;
      mie = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("T6_no_nmi_we", mepc_we, 0);
         chk("T6_no_nmi_rv", redirect_valid, 0);
      end
      chk("SB_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
